// File: rtl/imm_ext_unit_if.sv
// Request/response bundle for the immediate-extension unit: request on in_*, FIFO head on out_*.
interface imm_ext_unit_if #(
  parameter int DATA_W  = 32,
  parameter int IMM_W   = 12,
  parameter int SCALE_W = 2
);
  localparam int FW_W = $clog2(IMM_W + 1);

  logic               in_valid;
  logic               in_ready;
  logic [IMM_W-1:0]   in_imm;
  logic [FW_W-1:0]    in_fld_w;
  logic               in_signed;
  logic [SCALE_W-1:0] in_scale;
  logic               in_rot;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_imm;
  logic               out_err;

  modport slave (
    input  in_valid, in_imm, in_fld_w, in_signed, in_scale, in_rot, out_ready,
    output in_ready, out_valid, out_imm, out_err
  );

  modport master (
    output in_valid, in_imm, in_fld_w, in_signed, in_scale, in_rot, out_ready,
    input  in_ready, out_valid, out_imm, out_err
  );
endinterface

// File: rtl/imm_ext_unit.sv
// Decode-stage immediate extender: sign/zero extend + scale, or ARM rotated immediate,
// buffered in a DEPTH-entry FIFO with valid/ready on both sides.
module imm_ext_unit #(
  parameter int DATA_W  = 32,
  parameter int IMM_W   = 12,
  parameter int SCALE_W = 2,
  parameter int DEPTH   = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  imm_ext_unit_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [CNT_W-1:0]   count;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               push, pop;

  logic [DATA_W-1:0]   imm_x, ext, imm8_x, res;
  logic [2*DATA_W-1:0] rot2;
  logic [4:0]          rot_amt;
  logic                sbit, fld_err;

  always_comb begin
    imm_x   = DATA_W'(bus.in_imm);
    imm8_x  = DATA_W'(bus.in_imm[7:0]);
    rot_amt = {bus.in_imm[11:8], 1'b0};
    rot2    = {imm8_x, imm8_x} >> rot_amt;
    fld_err = (bus.in_fld_w == '0) || (int'(bus.in_fld_w) > IMM_W);
    sbit    = 1'b0;
    ext     = '0;
    for (int i = 0; i < DATA_W; i++)
      if (i == int'(bus.in_fld_w) - 1) sbit = imm_x[i];
    // Bits at or above the field width are replaced, so stray upper IMM bits never leak.
    for (int i = 0; i < DATA_W; i++)
      ext[i] = (i < int'(bus.in_fld_w)) ? imm_x[i] : (bus.in_signed & sbit);
    if (bus.in_rot)   res = rot2[DATA_W-1:0];
    else if (fld_err) res = '0;
    else              res = ext << bus.in_scale;
  end

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // Ready depends only on registered count, so a full FIFO never accepts, even while popping.
  assign bus.in_ready  = (count < CNT_W'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign bus.out_imm   = bus.out_valid ? mem[rd_ptr].data : '0;
  assign bus.out_err   = bus.out_valid ? mem[rd_ptr].err  : 1'b0;
  assign push = bus.in_valid  & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{err: fld_err & ~bus.in_rot, data: res};
        wr_ptr      <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_imm_ext_unit.sv
// Randomized + directed bench for imm_ext_unit with an arithmetic reference model and queue scoreboard.
module tb_imm_ext_unit;
  localparam int DATA_W = 32, IMM_W = 12, SCALE_W = 2, DEPTH = 2;

  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;

  imm_ext_unit_if #(.DATA_W(DATA_W), .IMM_W(IMM_W), .SCALE_W(SCALE_W)) bus ();
  imm_ext_unit #(.DATA_W(DATA_W), .IMM_W(IMM_W), .SCALE_W(SCALE_W), .DEPTH(DEPTH))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0, n_fail = 0;
  logic [32:0] q [$];   // {err, data}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic view of the rules: mask, two's-complement reinterpret, multiply by 2^scale.
  function automatic logic [32:0] model(input int imm, input int fw, input bit sg,
                                        input int sc, input bit rot);
    longint v, r;
    logic [63:0] w;
    if (rot) begin
      v = imm & 255;
      r = 2 * ((imm >> 8) & 15);
      w = ((v >> r) | (v << (32 - r))) & 64'hFFFF_FFFF;
      return {1'b0, w[31:0]};
    end
    if (fw == 0 || fw > IMM_W) return {1'b1, 32'h0};
    v = imm % (longint'(1) << fw);
    if (sg && v >= (longint'(1) << (fw - 1))) v = v - (longint'(1) << fw);
    w = (v * (longint'(1) << sc)) & 64'hFFFF_FFFF;
    return {1'b0, w[31:0]};
  endfunction

  // Scoreboard update at the active edge from pre-edge values.
  always @(posedge clk) if (rst_n) begin
    bit do_push, do_pop;
    do_push = bus.in_valid && (q.size() < DEPTH);
    do_pop  = (q.size() > 0) && bus.out_ready;
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(model(int'(bus.in_imm), int'(bus.in_fld_w), bus.in_signed,
                                   int'(bus.in_scale), bus.in_rot));
  end
  always @(negedge rst_n) q.delete();

  // Compare process, away from the active edge.
  always @(negedge clk) if (rst_n) begin
    chk("in_ready", bus.in_ready, q.size() < DEPTH);
    chk("out_valid", bus.out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_imm", bus.out_imm, q[0][31:0]);
      chk("out_err", bus.out_err, q[0][32]);
    end else begin
      chk("empty_imm", bus.out_imm, 0);
      chk("empty_err", bus.out_err, 0);
    end
  end

  task automatic idle();
    bus.in_valid = 0; bus.in_imm = '0; bus.in_fld_w = '0;
    bus.in_signed = 0; bus.in_scale = '0; bus.in_rot = 0;
  endtask

  task automatic push(input int imm, input int fw, input bit sg, input int sc, input bit rot);
    bit done = 0;
    @(posedge clk); #1;
    bus.in_valid = 1; bus.in_imm = IMM_W'(imm); bus.in_fld_w = 4'(fw);
    bus.in_signed = sg; bus.in_scale = SCALE_W'(sc); bus.in_rot = rot;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1;
      @(posedge clk); #1;
    end
    if (!done) chk("push_timeout", 1, 0);
    idle();
  endtask

  task automatic drain();
    bit done = 0;
    bus.out_ready = 1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (!bus.out_valid) done = 1;
    end
    if (!done) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    idle(); bus.out_ready = 1;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_imm", bus.out_imm, 0);
    chk("rst_out_err", bus.out_err, 0);
    #22 rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);

    // Literal pins on the model.
    chk("pin_s3",   model(3'b111, 3, 1, 0, 0),  {1'b0, 32'hFFFFFFFF});
    chk("pin_u3",   model(3'b111, 3, 0, 0, 0),  {1'b0, 32'h00000007});
    chk("pin_s11",  model(11'h7FF, 11, 1, 1, 0), {1'b0, 32'hFFFFFFFE});
    chk("pin_u8",   model(8'h80, 8, 0, 2, 0),   {1'b0, 32'h00000200});
    chk("pin_rot4", model(12'h4FF, 0, 0, 0, 1), {1'b0, 32'hFF000000});
    chk("pin_rot0", model(12'h0AB, 0, 0, 0, 1), {1'b0, 32'h000000AB});
    chk("pin_fw0",  model(12'hFFF, 0, 1, 0, 0), {1'b1, 32'h0});
    chk("pin_fw13", model(12'hFFF, 13, 1, 0, 0), {1'b1, 32'h0});

    // Directed vectors through the DUT.
    push(3'b111, 3, 1, 0, 0);   push(3'b111, 3, 0, 0, 0);
    push(11'h7FF, 11, 1, 1, 0); push(8'h80, 8, 0, 2, 0);
    push(12'h4FF, 5, 1, 3, 1);  push(12'h0AB, 0, 0, 0, 1);
    push(12'hFFF, 0, 1, 0, 0);  push(12'hFFF, 13, 0, 0, 0);
    push(12'h005, 12, 0, 0, 0);
    drain();

    // Back-pressure: A,B fill the FIFO, C must wait.
    bus.out_ready = 0;
    push(12'h011, 12, 0, 0, 0);
    push(12'h022, 12, 0, 0, 0);
    @(negedge clk);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_head", bus.out_imm, 32'h11);
    fork
      push(12'h033, 12, 0, 0, 0);
      begin repeat (3) @(posedge clk); #1 bus.out_ready = 1; end
    join
    drain();

    // Async reset with two entries queued.
    bus.out_ready = 0;
    push(12'h0AA, 8, 0, 0, 0);
    push(12'h0BB, 8, 0, 0, 0);
    @(posedge clk); #3 rst_n = 0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_imm", bus.out_imm, 0);
    #10 rst_n = 1;
    @(negedge clk);
    chk("postrst_in_ready", bus.in_ready, 1);
    chk("postrst_out_valid", bus.out_valid, 0);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_imm    = IMM_W'($urandom);
      bus.in_fld_w  = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'($urandom_range(1, 12));
      bus.in_signed = $urandom_range(0, 1);
      bus.in_scale  = SCALE_W'($urandom);
      bus.in_rot    = ($urandom_range(0, 3) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1 idle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
